// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment adder display path.
//
// Contents:
//   state_t / ST_*  - controller states (IDLE, CONV, DONE)
//   bcd_t           - one BCD digit (4 bits)
//   SEG_TABLE       - digit-to-segment patterns, bit0 = a ... bit6 = g, active-high
//   SEG_BLANK       - all segments off
//   seg_encode()    - table lookup; non-decimal codes map to blank
//   pow10()         - elaboration-time helper for sizing checks
package seg_pkg;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CONV = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [6:0] SEG_TABLE [10] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
    };

    function automatic logic [6:0] seg_encode(input bcd_t d);
        logic [6:0] code;
        code = SEG_BLANK;
        if (d <= 4'd9) begin
            code = SEG_TABLE[d];
        end
        return code;
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one iteration per cycle.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   start     - load bin and begin conversion (ignored while busy)
//   bin       - BIN_W-bit unsigned input
//   busy      - conversion in progress
//   done      - one-cycle pulse when bcd holds the finished result
//   bcd       - NUM_DIGITS packed BCD digits, digit 0 in bits [3:0]
//
// A conversion takes exactly BIN_W iterations; done rises on the edge that
// performs the last one.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int BIN_W      = 9,
    parameter int NUM_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd
);

    localparam int BCD_W  = 4 * NUM_DIGITS;
    localparam int ITER_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    logic [BIN_W-1:0]       bin_reg;
    logic [BCD_W-1:0]       bcd_reg;
    logic [ITER_W-1:0]      iter_reg;
    logic                   busy_reg;
    logic                   done_reg;
    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W+BIN_W-1:0] shifted;

    // Add 3 to every digit that is 5 or more before the shift doubles it.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
            bcd_t dig;
            assign dig = bcd_reg[gi*4 +: 4];
            assign bcd_adj[gi*4 +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
        end
    endgenerate

    assign shifted = {bcd_adj, bin_reg} << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_reg  <= '0;
            bcd_reg  <= '0;
            iter_reg <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start && !busy_reg) begin
                bin_reg  <= bin;
                bcd_reg  <= '0;
                iter_reg <= '0;
                busy_reg <= 1'b1;
            end else if (busy_reg) begin
                bcd_reg  <= shifted[BCD_W+BIN_W-1:BIN_W];
                bin_reg  <= shifted[BIN_W-1:0];
                iter_reg <= iter_reg + ITER_W'(1);
                if (iter_reg == ITER_W'(BIN_W - 1)) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign bcd  = bcd_reg;

endmodule

// File: rtl/seg_adder_scan.sv
// Registered, handshaked adder driving a time-multiplexed seven-segment display.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   in_valid/ready  - operand handshake; a transfer happens when both are high
//   a, b            - unsigned DATA_WIDTH-bit operands
//   done            - one-cycle pulse when a new result is loaded for display
//   led_carry       - bit DATA_WIDTH of the latest sum
//   seg             - segment pattern of the scanned digit (bit0 = a)
//   an              - one-hot digit enable, bit0 = least-significant digit
//
// Optional feature macro SEG_BLANK_LZ_EN: when defined, digits above the most
// significant non-zero digit are blanked (digit 0 always shown).
module seg_adder_scan
    import seg_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SEG_WIDTH  = 7,
    parameter int NUM_DIGITS = 3,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  done,
    output logic                  led_carry,
    output logic [SEG_WIDTH-1:0]  seg,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int SUM_W = DATA_WIDTH + 1;
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    generate
        if (pow10(NUM_DIGITS) <= ((64'd1 << SUM_W) - 64'd1)) begin : g_bad_digits
            $error("NUM_DIGITS too small for the largest sum");
        end
        if (SCAN_DIV < 1) begin : g_bad_div
            $error("SCAN_DIV must be at least 1");
        end
    endgenerate

    // ---------------- adder and controller ----------------
    logic [SUM_W-1:0] sum;
    logic             accept;
    state_t           state_reg;
    logic             carry_pend_reg;
    logic             led_carry_reg;
    logic [BCD_W-1:0] disp_reg;
    logic             conv_busy;
    logic             conv_done;
    logic [BCD_W-1:0] conv_bcd;

    assign sum      = SUM_W'(a) + SUM_W'(b);
    assign in_ready = (state_reg != ST_CONV);
    assign accept   = in_valid && in_ready;
    assign done     = (state_reg == ST_DONE);

    bin2bcd_seq #(
        .BIN_W      (SUM_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (accept),
        .bin   (sum),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            carry_pend_reg <= 1'b0;
            led_carry_reg  <= 1'b0;
            disp_reg       <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        carry_pend_reg <= sum[SUM_W-1];
                        state_reg      <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (conv_done && !conv_busy) begin
                        disp_reg      <= conv_bcd;
                        led_carry_reg <= carry_pend_reg;
                        state_reg     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (accept) begin
                        carry_pend_reg <= sum[SUM_W-1];
                        state_reg      <= ST_CONV;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign led_carry = led_carry_reg;

    // ---------------- per-digit segment codes ----------------
    logic [6:0] digit_code [NUM_DIGITS];

`ifdef SEG_BLANK_LZ_EN
    // zero_from[i]: digits i..NUM_DIGITS-1 are all zero.
    logic [NUM_DIGITS:1] zero_from;
    assign zero_from[NUM_DIGITS] = 1'b1;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            bcd_t dig;
            assign dig = disp_reg[gi*4 +: 4];
`ifdef SEG_BLANK_LZ_EN
            if (gi == 0) begin : g_lsd
                assign digit_code[gi] = seg_encode(dig);
            end else begin : g_upper
                if (gi < NUM_DIGITS) begin : g_zero
                    assign zero_from[gi] = (dig == 4'd0) && zero_from[gi+1];
                end
                assign digit_code[gi] = zero_from[gi] ? SEG_BLANK : seg_encode(dig);
            end
`else
            assign digit_code[gi] = seg_encode(dig);
`endif
        end
    endgenerate

    // ---------------- scan engine ----------------
    logic [CNT_W-1:0]      scan_cnt_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [IDX_W-1:0]      idx_next;
    logic                  scan_wrap;
    logic [SEG_WIDTH-1:0]  seg_reg;
    logic [NUM_DIGITS-1:0] an_reg;

    assign scan_wrap = (scan_cnt_reg == CNT_W'(SCAN_DIV - 1));

    always_comb begin
        idx_next = idx_reg;
        if (scan_wrap) begin
            idx_next = (idx_reg == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);
        end
    end

    // seg and an are both computed from idx_next so they switch together.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_reg <= '0;
            idx_reg      <= '0;
            an_reg       <= NUM_DIGITS'(1);
            seg_reg      <= SEG_WIDTH'(SEG_TABLE[0]);
        end else begin
            scan_cnt_reg <= scan_wrap ? '0 : scan_cnt_reg + CNT_W'(1);
            idx_reg      <= idx_next;
            an_reg       <= NUM_DIGITS'(1) << idx_next;
            seg_reg      <= SEG_WIDTH'(digit_code[idx_next]);
        end
    end

    assign seg = seg_reg;
    assign an  = an_reg;

endmodule

// File: tb/tb_seg_adder_scan.sv
module tb_seg_adder_scan;

    localparam int W  = 8;
    localparam int ND = 3;
    localparam int SD = 4;
    localparam int SW = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          in_ready;
    logic          done;
    logic          led_carry;
    logic [SW-1:0] seg;
    logic [ND-1:0] an;

    int tests = 0;
    int fails = 0;
    int k = 0;   // clock edges since the last reset edge

    seg_adder_scan #(
        .DATA_WIDTH (W),
        .SEG_WIDTH  (SW),
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .done      (done),
        .led_carry (led_carry),
        .seg       (seg),
        .an        (an)
    );

    always #5 clk = ~clk;

    always @(posedge clk) k <= rst ? 0 : k + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int i);
        int p;
        logic [6:0] r;
        p = 1;
        for (int j = 0; j < i; j++) p = p * 10;
        r = enc((v / p) % 10);
`ifdef SEG_BLANK_LZ_EN
        if (i > 0 && v < p) r = 7'b0000000;
`endif
        return r;
    endfunction

    // Checks an/seg for 12 cycles (one full scan) against the value v.
    task automatic check_display(input string name, input int v);
        int idx;
        logic [ND-1:0] e_an;
        for (int c = 0; c < 12; c++) begin
            idx  = (k / SD) % ND;
            e_an = 3'b001 << idx;
            tests++;
            if (an !== e_an) begin
                fails++;
                $display("FAIL %s an: got %b expected %b", name, an, e_an);
            end
            tests++;
            if (seg !== exp_seg(v, idx)) begin
                fails++;
                $display("FAIL %s seg digit%0d: got %b expected %b", name, idx, seg, exp_seg(v, idx));
            end
            @(negedge clk);
        end
    endtask

    task automatic send(input string name, input int av, input int bv);
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s in_ready before accept: got %b expected 1", name, in_ready);
        end
        a = W'(av);
        b = W'(bv);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_edges);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        while (!seen && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        tests++;
        if (!seen || n != exp_edges) begin
            fails++;
            $display("FAIL %s done latency: got %0d edges (seen=%0d) expected %0d", name, n, seen, exp_edges);
        end
    endtask

    // Called at the sampling point where done is high.
    task automatic check_result(input string name, input int v);
        tests++;
        if (led_carry !== (v > 255)) begin
            fails++;
            $display("FAIL %s led_carry: got %b expected %0d", name, led_carry, (v > 255));
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL %s done pulse width: got %b expected 0", name, done);
        end
        check_display(name, v);
    endtask

    task automatic run_txn(input string name, input int av, input int bv);
        send(name, av, bv);
        wait_done(name, 10);
        check_result(name, av + bv);
        $display("[TB] %s: %0d + %0d = %0d", name, av, bv, av + bv);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
        tests++;
        if (done !== 1'b0) begin fails++; $display("FAIL reset done: got %b expected 0", done); end
        tests++;
        if (led_carry !== 1'b0) begin fails++; $display("FAIL reset led_carry: got %b expected 0", led_carry); end
        tests++;
        if (seg !== 7'b0111111) begin fails++; $display("FAIL reset seg: got %b expected 0111111", seg); end
        tests++;
        if (an !== 3'b001) begin fails++; $display("FAIL reset an: got %b expected 001", an); end
        rst = 1'b0;
        // an must follow 001,010,100 with each held SD cycles from the reset edge.
        for (int c = 1; c <= 14; c++) begin
            logic [ND-1:0] e_an;
            @(negedge clk);
            e_an = 3'b001 << ((c / SD) % ND);
            tests++;
            if (an !== e_an) begin
                fails++;
                $display("FAIL scan cycle %0d an: got %b expected %b", c, an, e_an);
            end
        end
        $display("[TB] reset and scan sequence checked");
    endtask

    task automatic test_busy_ignore;
        int n;
        bit seen;
        int idx;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL busy in_ready idle: got %b expected 1", in_ready); end
        a = 8'd1;
        b = 8'd2;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        a = 8'd9;
        b = 8'd9;
        n = 0;
        seen = 0;
        while (!seen && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1;
            end else begin
                tests++;
                if (in_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL busy in_ready during conv edge %0d: got %b expected 0", n, in_ready);
                end
            end
        end
        tests++;
        if (!seen || n != 10) begin fails++; $display("FAIL busy first latency: got %0d expected 10", n); end
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL busy in_ready in done: got %b expected 1", in_ready); end
        tests++;
        if (led_carry !== 1'b0) begin fails++; $display("FAIL busy led_carry: got %b expected 0", led_carry); end
        // in_valid still high: the 9+9 pair is taken on the exiting edge.
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        seen = 0;
        while (!seen && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1;
            end else begin
                idx = (k / SD) % ND;
                tests++;
                if (seg !== exp_seg(3, idx)) begin
                    fails++;
                    $display("FAIL busy first result digit%0d: got %b expected %b", idx, seg, exp_seg(3, idx));
                end
            end
        end
        tests++;
        if (!seen || n != 10) begin fails++; $display("FAIL busy second latency: got %0d expected 10", n); end
        check_result("busy_second", 18);
        $display("[TB] busy_ignore: 1+2=3 then back-to-back 9+9=18");
    endtask

    task automatic test_random;
        int av;
        int bv;
        for (int t = 0; t < 6; t++) begin
            av = $urandom_range(0, 255);
            bv = $urandom_range(0, 255);
            run_txn("random", av, bv);
        end
    endtask

    task automatic test_reset_mid_conv;
        bit saw;
        send("rst_mid", 50, 60);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_mid in_ready: got %b expected 1", in_ready); end
        saw = 0;
        for (int c = 0; c < 15; c++) begin
            if (done === 1'b1) saw = 1;
            @(negedge clk);
        end
        tests++;
        if (saw) begin fails++; $display("FAIL rst_mid done pulse: got 1 expected 0"); end
        check_display("rst_mid", 0);
        $display("[TB] reset mid-conversion: display cleared");
    endtask

    initial begin
        test_reset();
        run_txn("carry_sum", 200, 100);
        run_txn("max_sum", 255, 255);
        test_busy_ignore();
        run_txn("leading_zeros", 3, 4);
        run_txn("zero_sum", 0, 0);
        test_random();
        test_reset_mid_conv();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
